// File: rtl/esp32_spi_pkg.sv
// Shared types and constants for the ESP32 button/LED SPI slave.
package esp32_spi_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } spi_state_e;

    // Byte position within a transaction; saturates at BYTE_PAD.
    localparam logic [1:0] BYTE_STATE  = 2'd0;
    localparam logic [1:0] BYTE_EVENTS = 2'd1;
    localparam logic [1:0] BYTE_PAD    = 2'd2;

    localparam logic [7:0] TX_PAD = 8'h00;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage single-bit synchroniser with asynchronous active-low reset (resets to 0).
module sync_2ff #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    if (Stages > 1) begin : g_multi
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[Stages-2:0], d_i};
            end
        end
    end else begin : g_single
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= d_i;
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/esp32_button_spi_slave.sv
// Oversampled SPI mode-0 slave: returns live buttons and latched press events, receives LED byte.
module esp32_button_spi_slave
    import esp32_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_buttons,
    input  logic              i_spi_csn,
    input  logic              i_spi_sck,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic [DATA_W-1:0] o_led,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic [1:0]        o_rx_index,
    output logic              o_busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic csn_s, sck_s, mosi_s;

    sync_2ff #(.Stages(SYNC_STAGES)) u_sync_csn (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (i_spi_csn),
        .q_o    (csn_s)
    );

    sync_2ff #(.Stages(SYNC_STAGES)) u_sync_sck (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (i_spi_sck),
        .q_o    (sck_s)
    );

    sync_2ff #(.Stages(SYNC_STAGES)) u_sync_mosi (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (i_spi_mosi),
        .q_o    (mosi_s)
    );

    spi_state_e        state_q, state_d;
    logic              csn_hist_q, sck_hist_q;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              done_q, done_d;
    logic [1:0]        done_idx_q, done_idx_d;
    logic              reload_q, reload_d;
    logic [DATA_W-1:0] clr_mask_q, clr_mask_d;
    logic [DATA_W-1:0] latch_q, latch_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [1:0]        rx_index_q, rx_index_d;

    logic              csn_fall, csn_rise, sck_rise, sck_fall;
    logic [DATA_W-1:0] clr;

    assign csn_fall = csn_hist_q & ~csn_s;
    assign csn_rise = ~csn_hist_q & csn_s;
    assign sck_rise = ~sck_hist_q & sck_s;
    assign sck_fall = sck_hist_q & ~sck_s;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        done_idx_d = done_idx_q;
        reload_d   = reload_q;
        clr_mask_d = clr_mask_q;
        miso_d     = miso_q;
        led_d      = led_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_index_d = rx_index_q;
        clr        = '0;

        unique case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d    = StShift;
                    tx_d       = i_buttons;
                    bit_cnt_d  = '0;
                    byte_idx_d = BYTE_STATE;
                    reload_d   = 1'b0;
                end
            end
            StShift: begin
                // CSn rise takes priority over any SCK edge seen in the same cycle.
                if (csn_rise) begin
                    state_d = StIdle;
                    if (byte_idx_q == BYTE_PAD) begin
                        clr = clr_mask_q;
                    end
                end else begin
                    miso_d = tx_q[DATA_W-1];
                    if (sck_rise) begin
                        rx_d = {rx_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            done_d     = 1'b1;
                            done_idx_d = byte_idx_q;
                            reload_d   = 1'b1;
                            if (byte_idx_q != BYTE_PAD) begin
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (reload_q) begin
                            reload_d = 1'b0;
                            if (byte_idx_q == BYTE_EVENTS) begin
                                tx_d       = latch_q;
                                clr_mask_d = latch_q;
                            end else begin
                                tx_d = DATA_W'(TX_PAD);
                            end
                        end else begin
                            tx_d = tx_q << 1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Completed byte is published one cycle after the final bit lands in rx_q.
        if (done_q) begin
            rx_data_d  = rx_q;
            rx_valid_d = 1'b1;
            rx_index_d = done_idx_q;
            if (done_idx_q == BYTE_STATE) begin
                led_d = rx_q;
            end
        end

        // Set has priority so a press coinciding with the clear is kept.
        latch_d = (latch_q & ~clr) | (i_buttons & ~prev_q);
        prev_d  = i_buttons;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            csn_hist_q <= 1'b0;
            sck_hist_q <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= BYTE_STATE;
            done_q     <= 1'b0;
            done_idx_q <= BYTE_STATE;
            reload_q   <= 1'b0;
            clr_mask_q <= '0;
            latch_q    <= '0;
            prev_q     <= '0;
            miso_q     <= 1'b0;
            led_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_index_q <= '0;
        end else begin
            state_q    <= state_d;
            csn_hist_q <= csn_s;
            sck_hist_q <= sck_s;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
            done_idx_q <= done_idx_d;
            reload_q   <= reload_d;
            clr_mask_q <= clr_mask_d;
            latch_q    <= latch_d;
            prev_q     <= prev_d;
            miso_q     <= miso_d;
            led_q      <= led_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_index_q <= rx_index_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = (state_q == StShift);
    assign o_busy        = (state_q == StShift);
    assign o_led         = led_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_index    = rx_index_q;

endmodule

// File: tb/tb_esp32_button_spi_slave.sv
// Directed bench: host-side SPI transactions at 1 MHz against the 25 MHz slave.
module tb_esp32_button_spi_slave;

    localparam time HALF = 500ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       spi_csn = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, rx_valid, busy;
    logic [7:0] led, rx_data;
    logic [1:0] rx_index;

    logic [7:0] host_mosi [4];
    logic [7:0] host_miso [4];
    logic [1:0] idx_log [64];
    int         valid_total = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         base;

    always #20ns clk = ~clk;

    esp32_button_spi_slave #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_buttons     (buttons),
        .i_spi_csn     (spi_csn),
        .i_spi_sck     (spi_sck),
        .i_spi_mosi    (spi_mosi),
        .o_spi_miso    (spi_miso),
        .o_spi_miso_oe (spi_miso_oe),
        .o_led         (led),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_rx_index    (rx_index),
        .o_busy        (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            if (valid_total < 64) idx_log[valid_total] = rx_index;
            valid_total = valid_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " miso"}, 32'(spi_miso), 32'h0);
        check_eq({tag, " oe"}, 32'(spi_miso_oe), 32'h0);
        check_eq({tag, " led"}, 32'(led), 32'h0);
        check_eq({tag, " rx_data"}, 32'(rx_data), 32'h0);
        check_eq({tag, " rx_valid"}, 32'(rx_valid), 32'h0);
        check_eq({tag, " rx_index"}, 32'(rx_index), 32'h0);
        check_eq({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    task automatic press(input logic [7:0] mask);
        @(negedge clk) buttons = mask;
        repeat (3) @(negedge clk);
        buttons = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // nbytes bytes, the last one only last_bits long; press_clr pulses button 2 in the
    // clear cycle after CSn rise; rst_byte aborts with reset at bit 3 of that byte.
    task automatic spi_xfer(input int nbytes, input int last_bits, input bit press_clr,
                            input int rst_byte);
        logic [7:0] rd;
        int nb;
        spi_csn = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1) ? last_bits : 8;
            rd = 8'h00;
            for (int i = 0; i < nb; i++) begin
                spi_mosi = host_mosi[b][7-i];
                #(HALF);
                rd = {rd[6:0], spi_miso};
                spi_sck = 1'b1;
                if (b == rst_byte && i == 3) begin
                    #(HALF / 2);
                    rst_n = 1'b0;
                    #1ns;
                    check_all_zero("mid-xfer reset");
                    #(HALF / 2);
                    rst_n = 1'b1;
                    #(HALF);
                    check_eq("busy after reset with CSn low", 32'(busy), 32'h0);
                    spi_sck = 1'b0;
                    #(HALF);
                    check_eq("no start from stale CSn", 32'(busy), 32'h0);
                    spi_csn = 1'b1;
                    #(2 * HALF);
                    return;
                end
                #(HALF);
                spi_sck = 1'b0;
            end
            host_miso[b] = rd;
        end
        #(HALF);
        spi_csn = 1'b1;
        if (press_clr) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk) buttons = 8'h04;
            repeat (4) @(negedge clk);
            buttons = 8'h00;
        end
        #(2 * HALF);
    endtask

    initial begin
        #7ns;
        #100ns;
        check_all_zero("reset");
        rst_n = 1'b1;
        #200ns;

        // Live button state on byte 0, LED byte from host.
        buttons = 8'hA5;
        #200ns;
        host_mosi[0] = 8'h3C;
        base = valid_total;
        spi_xfer(1, 8, 1'b0, -1);
        check_eq("t1 miso byte0", 32'(host_miso[0]), 32'hA5);
        check_eq("t1 led", 32'(led), 32'h3C);
        check_eq("t1 rx_data", 32'(rx_data), 32'h3C);
        check_eq("t1 valid count", 32'(valid_total - base), 32'd1);
        check_eq("t1 rx_index", 32'(idx_log[base]), 32'd0);
        check_eq("t1 oe after CSn rise", 32'(spi_miso_oe), 32'h0);

        // Events 0xA5 from the button rise; this read clears them.
        buttons = 8'h00;
        #200ns;
        host_mosi[0] = 8'h11; host_mosi[1] = 8'h22;
        base = valid_total;
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t2 byte0", 32'(host_miso[0]), 32'h00);
        check_eq("t2 byte1 events", 32'(host_miso[1]), 32'hA5);
        check_eq("t2 led", 32'(led), 32'h11);
        check_eq("t2 rx_data", 32'(rx_data), 32'h22);
        check_eq("t2 rx_index", 32'(rx_index), 32'd1);
        check_eq("t2 valid count", 32'(valid_total - base), 32'd2);

        // Press button 2 while idle.
        press(8'h04);
        host_mosi[0] = 8'h96; host_mosi[1] = 8'h00;
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t3 byte1 press", 32'(host_miso[1]), 32'h04);
        check_eq("t3 led", 32'(led), 32'h96);
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t3 byte1 cleared", 32'(host_miso[1]), 32'h00);

        // One-byte read does not clear.
        press(8'h04);
        host_mosi[0] = 8'h5A;
        spi_xfer(1, 8, 1'b0, -1);
        check_eq("t4 byte0", 32'(host_miso[0]), 32'h00);
        check_eq("t4 led", 32'(led), 32'h5A);
        host_mosi[0] = 8'h6B; host_mosi[1] = 8'h00;
        spi_xfer(2, 8, 1'b1, -1);
        check_eq("t4 byte1 kept", 32'(host_miso[1]), 32'h04);
        check_eq("t4 led 2", 32'(led), 32'h6B);

        // Press coinciding with the clear survives.
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t5 press in clear cycle", 32'(host_miso[1]), 32'h04);
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t5 cleared after", 32'(host_miso[1]), 32'h00);

        // Partial byte discarded.
        host_mosi[0] = 8'hFF;
        base = valid_total;
        spi_xfer(1, 5, 1'b0, -1);
        check_eq("t6 partial no valid", 32'(valid_total - base), 32'd0);
        check_eq("t6 partial led", 32'(led), 32'h6B);
        host_mosi[0] = 8'h81;
        base = valid_total;
        spi_xfer(1, 8, 1'b0, -1);
        check_eq("t6 after partial led", 32'(led), 32'h81);
        check_eq("t6 after partial valid", 32'(valid_total - base), 32'd1);
        check_eq("t6 after partial rx_data", 32'(rx_data), 32'h81);

        // Four-byte transaction with saturating index.
        press(8'h10);
        host_mosi[0] = 8'hC3; host_mosi[1] = 8'h01; host_mosi[2] = 8'h02; host_mosi[3] = 8'h03;
        base = valid_total;
        spi_xfer(4, 8, 1'b0, -1);
        check_eq("t7 byte0", 32'(host_miso[0]), 32'h00);
        check_eq("t7 byte1", 32'(host_miso[1]), 32'h10);
        check_eq("t7 byte2 pad", 32'(host_miso[2]), 32'h00);
        check_eq("t7 byte3 pad", 32'(host_miso[3]), 32'h00);
        check_eq("t7 valid count", 32'(valid_total - base), 32'd4);
        check_eq("t7 idx0", 32'(idx_log[base]), 32'd0);
        check_eq("t7 idx1", 32'(idx_log[base+1]), 32'd1);
        check_eq("t7 idx2", 32'(idx_log[base+2]), 32'd2);
        check_eq("t7 idx3", 32'(idx_log[base+3]), 32'd2);
        check_eq("t7 led", 32'(led), 32'hC3);
        check_eq("t7 rx_data", 32'(rx_data), 32'h03);

        // Reset during byte 3, then a clean transaction.
        host_mosi[0] = 8'h11; host_mosi[1] = 8'h22; host_mosi[2] = 8'h33; host_mosi[3] = 8'h44;
        spi_xfer(4, 8, 1'b0, 3);
        press(8'h08);
        host_mosi[0] = 8'h77; host_mosi[1] = 8'h55;
        base = valid_total;
        spi_xfer(2, 8, 1'b0, -1);
        check_eq("t8 byte0", 32'(host_miso[0]), 32'h00);
        check_eq("t8 byte1", 32'(host_miso[1]), 32'h08);
        check_eq("t8 led", 32'(led), 32'h77);
        check_eq("t8 rx_data", 32'(rx_data), 32'h55);
        check_eq("t8 rx_index", 32'(rx_index), 32'd1);
        check_eq("t8 valid count", 32'(valid_total - base), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
